pixel_frame_receiver: RTL and testbench

Sink end of the renderer's pixel stream (r/g/b + first/last_x/last_y + valid/ready). Accepts pixels under valid/ready handshake, tracks raster position, writes each pixel to a frame-buffer write port, and checks stream framing against the expected image geometry. Sits between the pixel-stream output of the top-level renderer and the frame buffer. Also serves as the bench-side checker.

---
 rtl/pixel_stream_if.sv | 27 ++
 rtl/pixel_frame_receiver.sv | 184 ++++++++++++++++++
 tb/tb_pixel_frame_receiver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_if.sv
// Pixel stream handshake bundle between the renderer (master) and a sink (slave).
//   r/g/b   : 8-bit colour components
//   first   : start of frame, qualified by valid
//   last_x  : last pixel of the current line, qualified by valid
//   last_y  : pixel belongs to the last line of the frame, qualified by valid
//   valid   : pixel present (master -> slave)
//   ready   : sink can accept (slave -> master)
interface pixel_stream_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       first;
  logic       last_x;
  logic       last_y;
  logic       valid;
  logic       ready;

  modport master (
    output r, g, b, first, last_x, last_y, valid,
    input  ready
  );

  modport slave (
    input  r, g, b, first, last_x, last_y, valid,
    output ready
  );
endinterface

// File: rtl/pixel_frame_receiver.sv
// Sink for the renderer pixel stream. Accepts pixels under valid/ready, tracks the raster
// position, writes each accepted pixel to a frame-buffer write port (latency 1) and flags
// framing errors against the expected IMAGE_W x IMAGE_H geometry.
//   clk, reset   : clock and synchronous active-high reset
//   pix          : pixel stream (slave side), ready = !fb_busy && not in the DONE cycle
//   fb_busy      : frame buffer stall request
//   clear_err    : clears the sticky error flags (a new error in the same cycle wins)
//   wr_en/addr/data : registered frame-buffer write port, data packed {b,g,r}
//   cur_x/cur_y  : next expected raster position
//   frame_done   : one-cycle pulse the cycle after the final pixel is accepted
//   frame_count  : completed frames, wraps
//   err_sof/eol/eof : sticky framing errors (first / last_x / last_y)
module pixel_frame_receiver #(
  parameter int unsigned IMAGE_W          = 640,
  parameter int unsigned IMAGE_H          = 480,
  parameter int unsigned PIXEL_DATA_WIDTH = 10,
  parameter int unsigned RBG_SIZE         = 24,
  parameter int unsigned ADDR_WIDTH       = 19,
  parameter int unsigned FRAME_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  pixel_stream_if.slave               pix,
  input  logic                        fb_busy,
  input  logic                        clear_err,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [RBG_SIZE-1:0]         wr_data,
  output logic [PIXEL_DATA_WIDTH-1:0] cur_x,
  output logic [PIXEL_DATA_WIDTH-1:0] cur_y,
  output logic                        frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]  frame_count,
  output logic                        err_sof,
  output logic                        err_eol,
  output logic                        err_eof
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] XLast = PIXEL_DATA_WIDTH'(IMAGE_W - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] YLast = PIXEL_DATA_WIDTH'(IMAGE_H - 1);

  typedef enum logic [1:0] {StHunt, StRecv, StDone} state_e;

  state_e                      state_q, state_d;
  logic [PIXEL_DATA_WIDTH-1:0] x_q, x_d;
  logic [PIXEL_DATA_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [FRAME_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                        wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
  logic [RBG_SIZE-1:0]         wr_data_q, wr_data_d;
  logic                        err_sof_q, err_sof_d;
  logic                        err_eol_q, err_eol_d;
  logic                        err_eof_q, err_eof_d;

  logic                        ready;
  logic                        xfer;
  logic                        resync;
  logic                        do_write;
  logic                        set_sof, set_eol, set_eof;
  logic                        at_x_last, at_final;
  logic [PIXEL_DATA_WIDTH-1:0] eff_x, eff_y;
  logic [ADDR_WIDTH-1:0]       eff_addr;

  // Ready never looks at valid so the source cannot form a combinational loop through us.
  assign ready     = !fb_busy && (state_q != StDone);
  assign pix.ready = ready;
  assign xfer      = pix.valid && ready;

  // A first flag (or hunting for one) pins the pixel to the origin.
  assign resync    = (state_q == StHunt) || pix.first;
  assign eff_x     = resync ? '0 : x_q;
  assign eff_y     = resync ? '0 : y_q;
  assign eff_addr  = resync ? '0 : addr_q;
  assign at_x_last = (eff_x == XLast);
  assign at_final  = at_x_last && (eff_y == YLast);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    do_write  = 1'b0;
    set_sof   = 1'b0;
    set_eol   = 1'b0;
    set_eof   = 1'b0;

    case (state_q)
      StHunt: begin
        if (xfer && !pix.first) begin
          set_sof = 1'b1;
        end else if (xfer) begin
          do_write = 1'b1;
        end
      end
      StRecv: begin
        if (xfer) begin
          do_write = 1'b1;
          // first is legal only on the origin pixel, which is also where it is mandatory.
          set_sof  = pix.first != ((x_q == '0) && (y_q == '0));
        end
      end
      StDone: begin
        state_d = StRecv;
      end
      default: begin
        state_d = StHunt;
      end
    endcase

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = eff_addr;
      wr_data_d = RBG_SIZE'({pix.b, pix.g, pix.r});
      set_eol   = pix.last_x != at_x_last;
      // last_y marks every pixel of the final line; it must be present on the final pixel.
      set_eof   = (pix.last_y && (eff_y != YLast)) || (!pix.last_y && at_final);
      if (at_final) begin
        state_d = StDone;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        state_d = StRecv;
        addr_d  = eff_addr + 1'b1;
        if (at_x_last) begin
          x_d = '0;
          y_d = eff_y + 1'b1;
        end else begin
          x_d = eff_x + 1'b1;
          y_d = eff_y;
        end
      end
    end

    err_sof_d = set_sof || (err_sof_q && !clear_err);
    err_eol_d = set_eol || (err_eol_q && !clear_err);
    err_eof_d = set_eof || (err_eof_q && !clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StHunt;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_sof_q <= 1'b0;
      err_eol_q <= 1'b0;
      err_eof_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_sof_q <= err_sof_d;
      err_eol_q <= err_eol_d;
      err_eof_q <= err_eof_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cur_x       = x_q;
  assign cur_y       = y_q;
  assign frame_done  = (state_q == StDone);
  assign frame_count = cnt_q;
  assign err_sof     = err_sof_q;
  assign err_eol     = err_eol_q;
  assign err_eof     = err_eof_q;

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Directed bench for pixel_frame_receiver on a 4x3 image with a 2-bit frame counter.
module tb_pixel_frame_receiver;

  logic        clk;
  logic        reset;
  logic        fb_busy;
  logic        clear_err;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;
  logic        frame_done;
  logic [1:0]  frame_count;
  logic        err_sof;
  logic        err_eol;
  logic        err_eof;

  pixel_stream_if pix ();

  pixel_frame_receiver #(
    .IMAGE_W         (4),
    .IMAGE_H         (3),
    .PIXEL_DATA_WIDTH(10),
    .RBG_SIZE        (24),
    .ADDR_WIDTH      (19),
    .FRAME_CNT_WIDTH (2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .pix        (pix.slave),
    .fb_busy    (fb_busy),
    .clear_err  (clear_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .err_sof    (err_sof),
    .err_eol    (err_eol),
    .err_eof    (err_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  // Every write strobe seen on the port, in order.
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(32'(wr_addr));
      wd.push_back(32'(wr_data));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] colour(input int k);
    logic [7:0] r, g, b;
    r = 8'(k);
    g = 8'(k + 16);
    b = 8'(k + 32);
    return {8'h00, b, g, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic f, input logic lx, input logic ly);
    pix.valid  = 1'b1;
    pix.r      = 8'(k);
    pix.g      = 8'(k + 16);
    pix.b      = 8'(k + 32);
    pix.first  = f;
    pix.last_x = lx;
    pix.last_y = ly;
  endtask

  // Holds the pixel until a handshake edge; returns just after that edge.
  task automatic send(input int k, input logic f, input logic lx, input logic ly);
    logic took;
    drive(k, f, lx, ly);
    took = 1'b0;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = pix.ready;
      @(posedge clk);
      #1;
    end
    pix.valid = 1'b0;
    check_eq("xfer_accepted", 32'(took), 32'd1);
  endtask

  task automatic send_std(input int k);
    send(k, k == 0, (k % 4) == 3, k >= 8);
  endtask

  task automatic send_frame();
    for (int k = 0; k < 12; k++) send_std(k);
  endtask

  task automatic check_log();
    check_eq("wr_count", 32'(wa.size()), 32'd12);
    for (int i = 0; i < 12 && i < wa.size(); i++) begin
      check_eq("wr_addr_seq", wa[i], 32'(i));
      check_eq("wr_data_seq", wd[i], colour(i));
    end
  endtask

  task automatic do_reset();
    pix.valid = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_no_err(input string tag);
    check_eq({tag, "_sof"}, 32'(err_sof), 32'd0);
    check_eq({tag, "_eol"}, 32'(err_eol), 32'd0);
    check_eq({tag, "_eof"}, 32'(err_eof), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    fb_busy   = 1'b0;
    clear_err = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    pix.valid = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_ready", 32'(pix.ready), 32'd1);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_eq("rst_cnt", 32'(frame_count), 32'd0);
    check_no_err("rst_err");

    // Clean frame
    for (int k = 0; k < 11; k++) send_std(k);
    check_eq("clean_no_done_early", 32'(frame_done), 32'd0);
    send_std(11);
    check_eq("clean_done", 32'(frame_done), 32'd1);
    check_eq("clean_ready_low", 32'(pix.ready), 32'd0);
    check_eq("clean_cnt", 32'(frame_count), 32'd1);
    check_eq("clean_pos_x", 32'(cur_x), 32'd0);
    check_eq("clean_pos_y", 32'(cur_y), 32'd0);
    tick();
    check_eq("clean_done_pulse", 32'(frame_done), 32'd0);
    check_eq("clean_ready_back", 32'(pix.ready), 32'd1);
    check_eq("clean_wr_idle", 32'(wr_en), 32'd0);
    check_log();
    check_no_err("clean_err");

    // Hunt for first
    do_reset();
    for (int k = 20; k < 23; k++) send(k, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("hunt_no_writes", 32'(wa.size()), 32'd0);
    check_eq("hunt_err_sof", 32'(err_sof), 32'd1);
    send_frame();
    tick();
    check_log();
    check_eq("hunt_cnt", 32'(frame_count), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("hunt_cleared", 32'(err_sof), 32'd0);

    // Backpressure on cycles 2-4 with valid held
    do_reset();
    send_std(0);
    send_std(1);
    drive(2, 1'b0, 1'b0, 1'b0);
    fb_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("bp_ready_low", 32'(pix.ready), 32'd0);
      check_eq("bp_pos_hold", 32'(cur_x), 32'd2);
      tick();
    end
    fb_busy = 1'b0;
    for (int k = 2; k < 12; k++) send_std(k);
    tick();
    check_log();
    check_no_err("bp_err");

    // Framing errors
    do_reset();
    send_std(0);
    send_std(1);
    send(2, 1'b0, 1'b1, 1'b0);
    check_eq("fe_err_eol", 32'(err_eol), 32'd1);
    send(3, 1'b0, 1'b0, 1'b0);
    check_eq("fe_p3_addr", 32'(wr_addr), 32'd3);
    check_eq("fe_p3_data", 32'(wr_data), colour(3));
    check_eq("fe_no_eof_yet", 32'(err_eof), 32'd0);
    for (int k = 4; k < 11; k++) send_std(k);
    send(11, 1'b0, 1'b1, 1'b0);
    check_eq("fe_err_eof", 32'(err_eof), 32'd1);
    check_eq("fe_done", 32'(frame_done), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_no_err("fe_cleared");
    for (int k = 0; k < 5; k++) send_std(k);
    check_eq("fe_no_sof_yet", 32'(err_sof), 32'd0);
    send(5, 1'b1, 1'b0, 1'b0);
    check_eq("fe_err_sof", 32'(err_sof), 32'd1);
    check_eq("fe_p5_wr_en", 32'(wr_en), 32'd1);
    check_eq("fe_p5_addr", 32'(wr_addr), 32'd0);
    check_eq("fe_p5_x", 32'(cur_x), 32'd1);
    check_eq("fe_p5_y", 32'(cur_y), 32'd0);

    // Reset mid-frame
    do_reset();
    for (int k = 0; k < 7; k++) send_std(k);
    reset = 1'b1;
    tick();
    check_eq("mid_ready", 32'(pix.ready), 32'd1);
    check_eq("mid_wr_en", 32'(wr_en), 32'd0);
    check_eq("mid_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("mid_wr_data", 32'(wr_data), 32'd0);
    check_eq("mid_x", 32'(cur_x), 32'd0);
    check_eq("mid_y", 32'(cur_y), 32'd0);
    check_eq("mid_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    wa.delete();
    wd.delete();
    send_frame();
    check_eq("mid_cnt", 32'(frame_count), 32'd1);
    tick();
    check_log();
    check_no_err("mid_err");

    // Frame counter wrap at 2 bits
    do_reset();
    for (int f = 1; f <= 4; f++) begin
      send_frame();
      check_eq("wrap_cnt", 32'(frame_count), 32'(f % 4));
    end
    tick();
    check_no_err("wrap_err");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
